// File: rtl/core_pkg.sv
// Shared RV32I core types: control bundle carried down the pipe, x0 index, default width.
package core_pkg;
    localparam int XLEN = 32;
    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] alu_op;
        logic       alu_src;
        logic       branch;
    } ctrl_t;
endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector: combinational, driven only by ID/EX state and ID addresses.
module hazard_detect
    import core_pkg::*;
(
    input  logic       valid_ex,
    input  logic       mem_read_ex,
    input  logic [4:0] rd_ex,
    input  logic [4:0] rs1_id,
    input  logic [4:0] rs2_id,
    input  logic       flush,
    input  logic       hold,
    output logic       hz,
    output logic       ctrl_zero,
    output logic       pc_write,
    output logic       if_id_write
);
    logic w_match;

    // rs2 is compared unconditionally; a false stall is cheaper than decoding format.
    assign w_match     = (rd_ex == rs1_id) | (rd_ex == rs2_id);
    assign hz          = valid_ex & mem_read_ex & (rd_ex != REG_ZERO) & w_match;
    assign ctrl_zero   = hz & ~flush & ~hold;
    // A flush discards the dependent instruction, so the fetch stall is released.
    assign pc_write    = ~hold & (~hz | flush);
    assign if_id_write = pc_write;
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection.
// Optional bubble/flush statistics counters enabled by defining ID_EX_STATS_EN.
module id_ex_stage
    import core_pkg::*;
#(
    parameter int XLEN  = core_pkg::XLEN,
    parameter int CNT_W = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            reg_write_id,
    input  logic            mem_to_reg_id,
    input  logic            mem_read_id,
    input  logic            mem_write_id,
    input  logic            alu_src_id,
    input  logic            branch_id,
    input  logic [1:0]      alu_op_id,
    input  logic [XLEN-1:0] pc_id,
    input  logic [XLEN-1:0] rd1_id,
    input  logic [XLEN-1:0] rd2_id,
    input  logic [XLEN-1:0] imm_id,
    input  logic [4:0]      rs1_id,
    input  logic [4:0]      rs2_id,
    input  logic [4:0]      rd_id,
    input  logic [2:0]      func3_id,
    input  logic            func7b5_id,
    input  logic            flush,
    input  logic            hold,
    output logic            ctrl_zero,
    output logic            pc_write,
    output logic            if_id_write,
    output logic            reg_write_ex,
    output logic            mem_to_reg_ex,
    output logic            mem_read_ex,
    output logic            mem_write_ex,
    output logic            alu_src_ex,
    output logic            branch_ex,
    output logic [1:0]      alu_op_ex,
    output logic [XLEN-1:0] pc_ex,
    output logic [XLEN-1:0] rd1_ex,
    output logic [XLEN-1:0] rd2_ex,
    output logic [XLEN-1:0] imm_ex,
    output logic [4:0]      rs1_ex,
    output logic [4:0]      rs2_ex,
    output logic [4:0]      rd_ex,
    output logic [2:0]      func3_ex,
    output logic            func7b5_ex,
`ifdef ID_EX_STATS_EN
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] flush_cnt,
`endif
    output logic            valid_ex
);
    ctrl_t           w_ctrl_id;
    ctrl_t           r_ctrl;
    logic            r_valid;
    logic [XLEN-1:0] r_pc, r_rd1, r_rd2, r_imm;
    logic [4:0]      r_rs1, r_rs2, r_rd;
    logic [2:0]      r_func3;
    logic            r_func7b5;
    logic            w_hz;

    assign w_ctrl_id = '{reg_write: reg_write_id, mem_to_reg: mem_to_reg_id,
                         mem_read: mem_read_id, mem_write: mem_write_id,
                         alu_op: alu_op_id, alu_src: alu_src_id, branch: branch_id};

    hazard_detect u_hazard (
        .valid_ex    (r_valid),
        .mem_read_ex (r_ctrl.mem_read),
        .rd_ex       (r_rd),
        .rs1_id      (rs1_id),
        .rs2_id      (rs2_id),
        .flush       (flush),
        .hold        (hold),
        .hz          (w_hz),
        .ctrl_zero   (ctrl_zero),
        .pc_write    (pc_write),
        .if_id_write (if_id_write)
    );

    // Flush outranks hold; data fields still load on flush since they are don't-care.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctrl    <= '0;
            r_valid   <= 1'b0;
            r_pc      <= '0;
            r_rd1     <= '0;
            r_rd2     <= '0;
            r_imm     <= '0;
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_rd      <= '0;
            r_func3   <= '0;
            r_func7b5 <= 1'b0;
        end else if (flush || !hold) begin
            r_ctrl    <= flush ? '0 : w_ctrl_id;
            r_valid   <= ~flush & ~ctrl_zero;
            r_pc      <= pc_id;
            r_rd1     <= rd1_id;
            r_rd2     <= rd2_id;
            r_imm     <= imm_id;
            r_rs1     <= rs1_id;
            r_rs2     <= rs2_id;
            r_rd      <= rd_id;
            r_func3   <= func3_id;
            r_func7b5 <= func7b5_id;
        end
    end

`ifdef ID_EX_STATS_EN
    logic [CNT_W-1:0] r_bubble_cnt, r_flush_cnt;

    // ctrl_zero is already masked by hold and flush, so bubbles freeze under hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bubble_cnt <= '0;
            r_flush_cnt  <= '0;
        end else begin
            if (ctrl_zero && r_bubble_cnt != '1) r_bubble_cnt <= r_bubble_cnt + 1'b1;
            if (flush && r_flush_cnt != '1)      r_flush_cnt  <= r_flush_cnt + 1'b1;
        end
    end

    assign bubble_cnt = r_bubble_cnt;
    assign flush_cnt  = r_flush_cnt;
`endif

    assign reg_write_ex  = r_ctrl.reg_write;
    assign mem_to_reg_ex = r_ctrl.mem_to_reg;
    assign mem_read_ex   = r_ctrl.mem_read;
    assign mem_write_ex  = r_ctrl.mem_write;
    assign alu_op_ex     = r_ctrl.alu_op;
    assign alu_src_ex    = r_ctrl.alu_src;
    assign branch_ex     = r_ctrl.branch;
    assign valid_ex      = r_valid;
    assign pc_ex         = r_pc;
    assign rd1_ex        = r_rd1;
    assign rd2_ex        = r_rd2;
    assign imm_ex        = r_imm;
    assign rs1_ex        = r_rs1;
    assign rs2_ex        = r_rs2;
    assign rd_ex         = r_rd;
    assign func3_ex      = r_func3;
    assign func7b5_ex    = r_func7b5;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage; counter checks are active when ID_EX_STATS_EN is defined.
module tb_id_ex_stage;
    localparam int XLEN  = 32;
    localparam int CNT_W = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            reg_write_id, mem_to_reg_id, mem_read_id, mem_write_id;
    logic            alu_src_id, branch_id;
    logic [1:0]      alu_op_id;
    logic [XLEN-1:0] pc_id, rd1_id, rd2_id, imm_id;
    logic [4:0]      rs1_id, rs2_id, rd_id;
    logic [2:0]      func3_id;
    logic            func7b5_id, flush, hold;
    logic            ctrl_zero, pc_write, if_id_write;
    logic            reg_write_ex, mem_to_reg_ex, mem_read_ex, mem_write_ex;
    logic            alu_src_ex, branch_ex, valid_ex, func7b5_ex;
    logic [1:0]      alu_op_ex;
    logic [XLEN-1:0] pc_ex, rd1_ex, rd2_ex, imm_ex;
    logic [4:0]      rs1_ex, rs2_ex, rd_ex;
    logic [2:0]      func3_ex;
`ifdef ID_EX_STATS_EN
    logic [CNT_W-1:0] bubble_cnt, flush_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .reg_write_id(reg_write_id), .mem_to_reg_id(mem_to_reg_id),
        .mem_read_id(mem_read_id), .mem_write_id(mem_write_id),
        .alu_src_id(alu_src_id), .branch_id(branch_id), .alu_op_id(alu_op_id),
        .pc_id(pc_id), .rd1_id(rd1_id), .rd2_id(rd2_id), .imm_id(imm_id),
        .rs1_id(rs1_id), .rs2_id(rs2_id), .rd_id(rd_id),
        .func3_id(func3_id), .func7b5_id(func7b5_id),
        .flush(flush), .hold(hold),
        .ctrl_zero(ctrl_zero), .pc_write(pc_write), .if_id_write(if_id_write),
        .reg_write_ex(reg_write_ex), .mem_to_reg_ex(mem_to_reg_ex),
        .mem_read_ex(mem_read_ex), .mem_write_ex(mem_write_ex),
        .alu_src_ex(alu_src_ex), .branch_ex(branch_ex), .alu_op_ex(alu_op_ex),
        .pc_ex(pc_ex), .rd1_ex(rd1_ex), .rd2_ex(rd2_ex), .imm_ex(imm_ex),
        .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .rd_ex(rd_ex),
        .func3_ex(func3_ex), .func7b5_ex(func7b5_ex),
`ifdef ID_EX_STATS_EN
        .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt),
`endif
        .valid_ex(valid_ex)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one ID instruction; unused controls/data held at fixed values.
    task automatic drive(input logic rw, input logic mr, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd, input logic [31:0] pc);
        reg_write_id = rw;  mem_read_id = mr;  mem_to_reg_id = mr;
        mem_write_id = 1'b0; alu_src_id = mr; branch_id = 1'b0; alu_op_id = mr ? 2'b00 : 2'b10;
        rs1_id = rs1; rs2_id = rs2; rd_id = rd; pc_id = pc;
        rd1_id = 32'h1111_0000 | pc; rd2_id = 32'h2222_0000 | pc; imm_id = {27'd0, rd};
        func3_id = 3'd2; func7b5_id = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        flush = 1'b0; hold = 1'b0; rst_n = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0);
        #12 rst_n = 1'b1;
        @(negedge clk);

        // Normal add, then async reset mid-cycle with non-zero inputs.
        drive(1'b1, 1'b0, 5'd1, 5'd2, 5'd3, 32'h40);
        step();
        chk("load_pc", pc_ex, 32'h40);
        chk("load_valid", valid_ex, 1);
        chk("load_rw", reg_write_ex, 1);
        chk("load_rd1", rd1_ex, 32'h1111_0040);
        drive(1'b1, 1'b1, 5'd4, 5'd5, 5'd6, 32'h44);
        step();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_valid", valid_ex, 0);
        chk("rst_pc", pc_ex, 0);
        chk("rst_memread", mem_read_ex, 0);
        chk("rst_rd", rd_ex, 0);
        chk("rst_ctrl_zero", ctrl_zero, 0);
        chk("rst_pc_write", pc_write, 1);
        chk("rst_if_id_write", if_id_write, 1);
`ifdef ID_EX_STATS_EN
        chk("rst_bubble_cnt", bubble_cnt, 0);
        chk("rst_flush_cnt", flush_cnt, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // lw x5 then add x6,x5,x7: one bubble.
        drive(1'b1, 1'b1, 5'd1, 5'd0, 5'd5, 32'h100);
        step();
        chk("lw_memread", mem_read_ex, 1);
        chk("lw_valid", valid_ex, 1);
        drive(1'b0, 1'b0, 5'd5, 5'd7, 5'd6, 32'h104);   // controls zeroed by upstream mux
        #1;
        chk("hz_ctrl_zero", ctrl_zero, 1);
        chk("hz_pc_write", pc_write, 0);
        chk("hz_if_id_write", if_id_write, 0);
        step();
        chk("bubble_valid", valid_ex, 0);
        chk("bubble_rw", reg_write_ex, 0);
        chk("bubble_ctrl_zero", ctrl_zero, 0);
        chk("bubble_pc_write", pc_write, 1);
`ifdef ID_EX_STATS_EN
        chk("bubble_cnt1", bubble_cnt, 1);
`endif
        drive(1'b1, 1'b0, 5'd5, 5'd7, 5'd6, 32'h104);
        step();
        chk("add_valid", valid_ex, 1);
        chk("add_rw", reg_write_ex, 1);
        chk("add_rd", rd_ex, 6);
        chk("add_pc", pc_ex, 32'h104);

        // lw x0 then use of x0: no stall.
        drive(1'b1, 1'b1, 5'd1, 5'd0, 5'd0, 32'h108);
        step();
        drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd8, 32'h10c);
        #1;
        chk("x0_ctrl_zero", ctrl_zero, 0);
        chk("x0_pc_write", pc_write, 1);

        // Flush coincident with a load-use hazard (hazard via rs2).
        drive(1'b1, 1'b1, 5'd1, 5'd0, 5'd5, 32'h110);
        step();
        drive(1'b1, 1'b0, 5'd9, 5'd5, 5'd6, 32'h114);
        flush = 1'b1;
        #1;
        chk("fl_ctrl_zero", ctrl_zero, 0);
        chk("fl_pc_write", pc_write, 1);
        step();
        flush = 1'b0;
        chk("fl_valid", valid_ex, 0);
        chk("fl_rw", reg_write_ex, 0);
        chk("fl_pc_data", pc_ex, 32'h114);
`ifdef ID_EX_STATS_EN
        chk("fl_flush_cnt", flush_cnt, 1);
        chk("fl_bubble_cnt", bubble_cnt, 1);
`endif

        // Hold for 3 cycles with pc 0x100 in EX.
        drive(1'b1, 1'b0, 5'd1, 5'd2, 5'd3, 32'h100);
        step();
        chk("hold_pre_pc", pc_ex, 32'h100);
        drive(1'b1, 1'b1, 5'd4, 5'd4, 5'd4, 32'h200);
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_pc", pc_ex, 32'h100);
            chk("hold_pc_write", pc_write, 0);
            chk("hold_memread", mem_read_ex, 0);
`ifdef ID_EX_STATS_EN
            chk("hold_bubble_cnt", bubble_cnt, 1);
            chk("hold_flush_cnt", flush_cnt, 1);
`endif
        end
        // Hold plus flush: flush wins.
        flush = 1'b1;
        step();
        flush = 1'b0;
        hold  = 1'b0;
        chk("hf_valid", valid_ex, 0);
        chk("hf_pc", pc_ex, 32'h200);
        chk("hf_memread", mem_read_ex, 0);
`ifdef ID_EX_STATS_EN
        chk("hf_flush_cnt", flush_cnt, 2);
`endif

        // 20 more load-use bubbles: counter saturates at 15.
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b1, 5'd1, 5'd0, 5'd5, 32'h300);
            step();
            drive(1'b0, 1'b0, 5'd5, 5'd7, 5'd6, 32'h304);
            #1;
            if (i == 0) chk("sat_ctrl_zero", ctrl_zero, 1);
            step();
`ifdef ID_EX_STATS_EN
            if (i == 9) chk("sat_mid_cnt", bubble_cnt, 11);
`endif
        end
        chk("sat_valid", valid_ex, 0);
`ifdef ID_EX_STATS_EN
        chk("sat_bubble_cnt", bubble_cnt, 15);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
